// File: rtl/bsg_fma_pkg.sv
// Shared types and limits for the FMA auxiliary cross-term adder.
package bsg_fma_pkg;

  localparam int unsigned max_aux_stages_gp = 2;
  localparam int unsigned max_aux_width_gp  = 32;

  // Fields are sized for the widest supported width_p; narrower users zero-fill the top.
  typedef struct packed {
    logic [max_aux_width_gp-1:0] sum;
    logic [max_aux_width_gp-1:0] carry;
  } bsg_fma_aux_csa_s;

endpackage

// File: rtl/bsg_fma_aux_csa_tree.sv
// Combinational 3:2 carry-save reduction of rows_p width_p-bit rows to a sum/carry pair.
module bsg_fma_aux_csa_tree
  import bsg_fma_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned rows_p  = 16
) (
  input  logic [rows_p-1:0][width_p-1:0] rows_i,
  output bsg_fma_aux_csa_s               csa_o
);

  if (rows_p < 2) begin : g_bad_rows
    $error("bsg_fma_aux_csa_tree: rows_p must be at least 2");
  end
  if (width_p > max_aux_width_gp) begin : g_bad_width
    $error("bsg_fma_aux_csa_tree: width_p exceeds max_aux_width_gp");
  end

  logic [width_p-1:0] w_sum;
  logic [width_p-1:0] w_carry;
  logic [width_p-1:0] w_row;
  logic [width_p-1:0] w_maj;

  // Each 3:2 step folds one more row in; the shifted-out carry bit is the mod 2^width_p drop.
  always_comb begin
    w_row   = '0;
    w_maj   = '0;
    w_sum   = rows_i[0];
    w_carry = rows_i[1];
    for (int unsigned i = 2; i < rows_p; i++) begin
      w_row   = rows_i[i];
      w_maj   = (w_sum & w_carry) | (w_sum & w_row) | (w_carry & w_row);
      w_sum   = w_sum ^ w_carry ^ w_row;
      w_carry = w_maj << 1;
    end
  end

  always_comb begin
    csa_o                      = '0;
    csa_o.sum[width_p-1:0]     = w_sum;
    csa_o.carry[width_p-1:0]   = w_carry;
  end

endmodule

// File: rtl/bsg_fma_aux_adder_pipe.sv
// Pipelined (a_h*b_l + a_l*b_h) mod 2^width_p with valid/yumi flow control.
// Optional counters ops_o/stall_o are built when BSG_FMA_AUX_ADDER_PERF_EN is defined.
module bsg_fma_aux_adder_pipe
  import bsg_fma_pkg::*;
#(
  parameter int unsigned width_p     = 8,
  parameter int unsigned stages_p    = 2,
  parameter int unsigned tag_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     a_l_i,
  input  logic [width_p-1:0]     a_h_i,
  input  logic [width_p-1:0]     b_l_i,
  input  logic [width_p-1:0]     b_h_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic [width_p-1:0]     mod_o,
  output logic [tag_width_p-1:0] tag_o
`ifdef BSG_FMA_AUX_ADDER_PERF_EN
  ,
  output logic [31:0]            ops_o,
  output logic [31:0]            stall_o
`endif
);

  if (stages_p < 1 || stages_p > max_aux_stages_gp) begin : g_bad_stages
    $error("bsg_fma_aux_adder_pipe: stages_p must be 1 or 2");
  end

  logic [2*width_p-1:0][width_p-1:0] w_rows;
  bsg_fma_aux_csa_s                  w_csa;
  logic [2*max_aux_width_gp-1:0]     w_unused_csa;
  logic [width_p-1:0]                w_sum;
  logic [width_p-1:0]                w_carry;
  logic                              w_accept;

  always_comb begin
    w_rows = '0;
    for (int unsigned i = 0; i < width_p; i++) begin
      w_rows[i]         = ({width_p{b_l_i[i]}} & a_h_i) << i;
      w_rows[i+width_p] = ({width_p{b_h_i[i]}} & a_l_i) << i;
    end
  end

  bsg_fma_aux_csa_tree #(
    .width_p (width_p),
    .rows_p  (2*width_p)
  ) u_csa (
    .rows_i (w_rows),
    .csa_o  (w_csa)
  );

  assign w_unused_csa = w_csa;
  assign w_sum        = w_csa.sum[width_p-1:0];
  assign w_carry      = w_csa.carry[width_p-1:0];
  assign w_accept     = v_i & ready_o;

  if (stages_p == 1) begin : g_one
    logic                   r_v;
    logic [width_p-1:0]     r_mod;
    logic [tag_width_p-1:0] r_tag;
    logic                   w_adv0;

    assign w_adv0  = r_v & yumi_i;
    assign ready_o = ~r_v | w_adv0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_v   <= 1'b0;
        r_mod <= '0;
        r_tag <= '0;
      end else if (w_accept) begin
        r_v   <= 1'b1;
        r_mod <= w_sum + w_carry;
        r_tag <= tag_i;
      end else if (w_adv0) begin
        r_v   <= 1'b0;
      end
    end

    assign v_o   = r_v;
    assign mod_o = r_mod;
    assign tag_o = r_tag;
  end else begin : g_two
    logic                   r_v0;
    logic [width_p-1:0]     r_s0_sum;
    logic [width_p-1:0]     r_s0_carry;
    logic [tag_width_p-1:0] r_tag0;
    logic                   r_v1;
    logic [width_p-1:0]     r_mod;
    logic [tag_width_p-1:0] r_tag1;
    logic                   w_adv0;
    logic                   w_adv1;

    // S0 may advance into S1 in the same cycle S1 is consumed, so no bubble is inserted.
    assign w_adv1  = r_v1 & yumi_i;
    assign w_adv0  = r_v0 & (~r_v1 | w_adv1);
    assign ready_o = ~r_v0 | w_adv0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_v0       <= 1'b0;
        r_s0_sum   <= '0;
        r_s0_carry <= '0;
        r_tag0     <= '0;
      end else if (w_accept) begin
        r_v0       <= 1'b1;
        r_s0_sum   <= w_sum;
        r_s0_carry <= w_carry;
        r_tag0     <= tag_i;
      end else if (w_adv0) begin
        r_v0       <= 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_v1   <= 1'b0;
        r_mod  <= '0;
        r_tag1 <= '0;
      end else if (w_adv0) begin
        r_v1   <= 1'b1;
        r_mod  <= r_s0_sum + r_s0_carry;
        r_tag1 <= r_tag0;
      end else if (w_adv1) begin
        r_v1   <= 1'b0;
      end
    end

    assign v_o   = r_v1;
    assign mod_o = r_mod;
    assign tag_o = r_tag1;
  end

`ifdef BSG_FMA_AUX_ADDER_PERF_EN
  logic [31:0] r_ops;
  logic [31:0] r_stall;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ops   <= '0;
      r_stall <= '0;
    end else begin
      if (w_accept)        r_ops   <= r_ops + 32'd1;
      if (v_o && !yumi_i)  r_stall <= r_stall + 32'd1;
    end
  end

  assign ops_o   = r_ops;
  assign stall_o = r_stall;
`endif

  a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("bsg_fma_aux_adder_pipe: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_fma_aux_adder_pipe.sv
// Scoreboard bench for bsg_fma_aux_adder_pipe: driver pushes expected results, monitor pops on v_o.
module tb_bsg_fma_aux_adder_pipe;

  localparam int unsigned W      = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TW     = 4;

  typedef struct {
    logic [W-1:0]  mod;
    logic [TW-1:0] tag;
    int            acc;
  } item_t;

  logic          clk;
  logic          reset_n_i;
  logic          v_i;
  logic          ready_o;
  logic [W-1:0]  a_l_i, a_h_i, b_l_i, b_h_i;
  logic [TW-1:0] tag_i;
  logic          v_o;
  logic          yumi_i;
  logic [W-1:0]  mod_o;
  logic [TW-1:0] tag_o;
`ifdef BSG_FMA_AUX_ADDER_PERF_EN
  logic [31:0]   ops_o;
  logic [31:0]   stall_o;
`endif

  bsg_fma_aux_adder_pipe #(
    .width_p     (W),
    .stages_p    (STAGES),
    .tag_width_p (TW)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .a_l_i     (a_l_i),
    .a_h_i     (a_h_i),
    .b_l_i     (b_l_i),
    .b_h_i     (b_h_i),
    .tag_i     (tag_i),
    .v_o       (v_o),
    .yumi_i    (yumi_i),
    .mod_o     (mod_o),
    .tag_o     (tag_o)
`ifdef BSG_FMA_AUX_ADDER_PERF_EN
    ,
    .ops_o     (ops_o),
    .stall_o   (stall_o)
`endif
  );

  item_t q[$];
  int    n_asserts = 0;
  int    n_fail    = 0;
  int    cyc       = 0;
  int    yumi_pct  = 100;
  bit    yumi_now  = 0;
  int    exp_ops   = 0;
  int    exp_stall = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] ah, bl, al, bh);
    longint unsigned s;
    s = longint'(ah) * longint'(bl) + longint'(al) * longint'(bh);
    return W'(s % (64'd1 << W));
  endfunction

  // Monitor: v_o must appear exactly STAGES-1 edges after the accepting edge of the oldest op.
  initial begin
    yumi_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        yumi_i   = 1'b0;
        yumi_now = 0;
      end else begin
        bit exp_v;
        exp_v = (q.size() > 0) && (cyc >= q[0].acc + int'(STAGES) - 1);
        check("v_o", 32'(v_o), 32'(exp_v));
        if (v_o && exp_v) begin
          check("mod_o", 32'(mod_o), 32'(q[0].mod));
          check("tag_o", 32'(tag_o), 32'(q[0].tag));
        end
        yumi_i   = v_o && ($urandom_range(0, 99) < yumi_pct);
        yumi_now = yumi_i;
        if (v_o && !yumi_i) exp_stall++;
        if (yumi_i && q.size() > 0) void'(q.pop_front());
      end
    end
  end

  task automatic issue(input bit vld, input logic [W-1:0] ah, bl, al, bh, input logic [TW-1:0] tg);
    int occ;
    item_t it;
    @(negedge clk);
    v_i = vld; a_h_i = ah; b_l_i = bl; a_l_i = al; b_h_i = bh; tag_i = tg;
    #1;
    occ = q.size() + (yumi_now ? 1 : 0);
    check("ready_o", 32'(ready_o), 32'((occ < int'(STAGES)) || yumi_now));
    if (vld && ready_o) begin
      it.mod = ref_mod(ah, bl, al, bh);
      it.tag = tg;
      it.acc = cyc + 1;
      q.push_back(it);
      exp_ops++;
    end
  endtask

  task automatic issue_rand(input bit vld);
    issue(vld, W'($urandom), W'($urandom), W'($urandom), W'($urandom), TW'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    reset_n_i = 1'b0;
    v_i = 1'b0; a_l_i = '0; a_h_i = '0; b_l_i = '0; b_h_i = '0; tag_i = '0;
    #1;
    check("reset_v_o",     32'(v_o),     32'd0);
    check("reset_mod_o",   32'(mod_o),   32'd0);
    check("reset_tag_o",   32'(tag_o),   32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset_n_i = 1'b1;

    // Directed: 3*5 + 2*7 = 0x1D, and all-ones 0x1FC02 truncates to 0x02.
    yumi_pct = 100;
    issue(1, 8'd3, 8'd5, 8'd2, 8'd7, 4'hA);
    idle(3);
    issue(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h5);
    idle(3);

    // Back-to-back at full throughput.
    for (int i = 0; i < 4; i++) issue_rand(1);
    idle(4);

    // Backpressure: only STAGES ops fit, held outputs must stay stable, then drain in order.
    yumi_pct = 0;
    for (int i = 0; i < 5; i++) issue_rand(1);
    yumi_pct = 100;
    idle(5);
    check("backpressure_drain", 32'(q.size()), 32'd0);

    // Reset mid-flight with two ops pending.
    yumi_pct = 0;
    issue_rand(1);
    issue_rand(1);
    idle(1);
    @(negedge clk);
    #2 reset_n_i = 1'b0;
    #1;
    check("midreset_v_o",   32'(v_o),   32'd0);
    check("midreset_mod_o", 32'(mod_o), 32'd0);
    check("midreset_tag_o", 32'(tag_o), 32'd0);
    q.delete();
    exp_ops   = 0;
    exp_stall = 0;
    @(negedge clk);
    #2 reset_n_i = 1'b1;
    yumi_pct = 100;
    idle(4);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) yumi_pct = int'($urandom_range(20, 100));
      issue_rand($urandom_range(0, 99) < 70);
    end

    yumi_pct = 100;
    for (int k = 0; k < 50 && q.size() != 0; k++) idle(1);
    check("final_drain", 32'(q.size()), 32'd0);
    idle(2);

`ifdef BSG_FMA_AUX_ADDER_PERF_EN
    check("ops_o",   ops_o,   32'(exp_ops));
    check("stall_o", stall_o, 32'(exp_stall));
`else
    $display("info: %0d ops accepted, %0d stall cycles since last reset", exp_ops, exp_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
